// File: rtl/hdmi_pkg.sv
// Shared defaults and types for the HDMI sliding-window generator.
package hdmi_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CHANNELS   = 3;
  localparam int DEF_KERNEL     = 5;
  localparam int DEF_MAX_LINE   = 2048;

  localparam logic BORDER_ZERO = 1'b0;
  localparam logic BORDER_REPL = 1'b1;

  typedef struct packed {
    logic dv;
    logic hs;
    logic vs;
  } sync_t;
endpackage

// File: rtl/hdmi_line_ram.sv
// Simple dual-port line memory with registered, read-first output. Not reset.
module hdmi_line_ram #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 2048,
  parameter int AW    = 11
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/hdmi_window_gen.sv
// Trailing KERNELxKERNEL window generator over a raster pixel stream, 2-cycle latency.
// The win bus is laid out per channel so downstream median filters take it unchanged.
module hdmi_window_gen
  import hdmi_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CHANNELS   = DEF_CHANNELS,
  parameter int KERNEL     = DEF_KERNEL,
  parameter int MAX_LINE   = DEF_MAX_LINE
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [CHANNELS*DATA_WIDTH-1:0]             in_data,
  input  logic                                       in_dv,
  input  logic                                       in_hs,
  input  logic                                       in_vs,
  input  logic                                       border_mode,
  output logic [CHANNELS*KERNEL*KERNEL*DATA_WIDTH-1:0] win,
  output logic                                       out_dv,
  output logic                                       out_hs,
  output logic                                       out_vs,
  output logic                                       ovf
);
  localparam int PW = CHANNELS*DATA_WIDTH;
  localparam int WW = CHANNELS*KERNEL*KERNEL*DATA_WIDTH;
  localparam int NR = KERNEL-1;
  localparam int AW = (MAX_LINE > 1) ? $clog2(MAX_LINE) : 1;
  localparam int CW = $clog2(MAX_LINE+1);
  localparam int KW = $clog2(KERNEL);

  typedef struct packed {
    sync_t         sync;
    logic [PW-1:0] pix;
    logic [AW-1:0] addr;
    logic          wr;
    logic [KW-1:0] rmin;
    logic [KW-1:0] cmin;
    logic          bm;
    logic          vsr;
    logic          ovfpx;
  } s1_t;

  logic [CW-1:0] col_q, col_d, x;
  logic [KW-1:0] line_q, line_d, y;
  logic          dv_prev_q, dv_prev_d, vs_prev_q, vs_prev_d, bmode_q, bmode_d;
  logic          vs_rise, in_range;
  logic [AW-1:0] addr;
  s1_t           s1_q, s1_d;
  sync_t         sync2_q, sync2_d;
  logic [WW-1:0] win_q, win_d;
  logic          ovf_q, ovf_d;
  logic [PW-1:0] rd [NR];
  logic [PW-1:0] newcol [KERNEL];
  logic [PW-1:0] raw [KERNEL][KERNEL];
  logic [PW-1:0] colsr_q [KERNEL-1][KERNEL];
  logic [PW-1:0] colsr_d [KERNEL-1][KERNEL];
  logic [PW-1:0] px;
  logic [KW-1:0] rs, cs;

  // Stage 0: raster position; a vsync rise wins over everything, even with a live pixel.
  always_comb begin
    vs_rise   = in_vs & ~vs_prev_q;
    x         = vs_rise ? '0 : col_q;
    y         = vs_rise ? '0 : line_q;
    in_range  = (x < CW'(MAX_LINE));
    addr      = in_range ? x[AW-1:0] : '0;
    dv_prev_d = in_dv;
    vs_prev_d = in_vs;
    col_d     = col_q;
    line_d    = line_q;
    bmode_d   = bmode_q;
    if (vs_rise) begin
      col_d   = in_dv ? CW'(1) : '0;
      line_d  = '0;
      bmode_d = border_mode;
    end else if (in_dv) begin
      if (col_q != CW'(MAX_LINE)) col_d = col_q + 1'b1;
    end else if (dv_prev_q) begin
      col_d = '0;
      if (line_q != KW'(KERNEL-1)) line_d = line_q + 1'b1;
    end
    s1_d.sync  = '{dv: in_dv, hs: in_hs, vs: in_vs};
    s1_d.pix   = in_data;
    s1_d.addr  = addr;
    s1_d.wr    = in_range;
    s1_d.rmin  = KW'(KERNEL-1) - y;
    s1_d.cmin  = (int'(x) >= KERNEL-1) ? '0 : KW'(KERNEL-1-int'(x));
    s1_d.bm    = vs_rise ? border_mode : bmode_q;
    s1_d.vsr   = vs_rise;
    s1_d.ovfpx = in_dv & ~in_range;
  end

  // RAM i holds line y-1-i; each RAM forwards its read data into the next one.
  for (genvar i = 0; i < NR; i++) begin : g_lr
    if (i == 0) begin : g_head
      hdmi_line_ram #(.WIDTH(PW), .DEPTH(MAX_LINE), .AW(AW)) u_ram (
        .clk(clk), .we(in_dv & in_range), .waddr(addr), .wdata(in_data),
        .raddr(addr), .rdata(rd[i]));
    end else begin : g_tail
      hdmi_line_ram #(.WIDTH(PW), .DEPTH(MAX_LINE), .AW(AW)) u_ram (
        .clk(clk), .we(s1_q.sync.dv & s1_q.wr), .waddr(s1_q.addr), .wdata(rd[i-1]),
        .raddr(addr), .rdata(rd[i]));
    end
  end

  always_comb begin
    newcol[KERNEL-1] = s1_q.pix;
    for (int r = 0; r < KERNEL-1; r++) newcol[r] = rd[KERNEL-2-r];
    for (int r = 0; r < KERNEL; r++) begin
      for (int c = 0; c < KERNEL-1; c++) raw[r][c] = colsr_q[c][r];
      raw[r][KERNEL-1] = newcol[r];
    end
  end

  // Stage 1: column history shifts and the border mask is applied to the raw window.
  always_comb begin
    colsr_d = colsr_q;
    win_d   = win_q;
    rs      = '0;
    cs      = '0;
    px      = '0;
    if (s1_q.sync.dv) begin
      for (int c = 0; c < KERNEL-2; c++) colsr_d[c] = colsr_q[c+1];
      for (int r = 0; r < KERNEL; r++) colsr_d[KERNEL-2][r] = newcol[r];
      for (int r = 0; r < KERNEL; r++) begin
        for (int c = 0; c < KERNEL; c++) begin
          rs = (KW'(r) < s1_q.rmin) ? s1_q.rmin : KW'(r);
          cs = (KW'(c) < s1_q.cmin) ? s1_q.cmin : KW'(c);
          if (s1_q.bm == BORDER_REPL)                            px = raw[rs][cs];
          else if (KW'(r) < s1_q.rmin || KW'(c) < s1_q.cmin)     px = '0;
          else                                                   px = raw[r][c];
          for (int ch = 0; ch < CHANNELS; ch++)
            win_d[((ch*KERNEL*KERNEL)+r*KERNEL+c)*DATA_WIDTH +: DATA_WIDTH] =
              px[ch*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
    sync2_d = s1_q.sync;
    ovf_d   = s1_q.vsr ? s1_q.ovfpx : (ovf_q | s1_q.ovfpx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q     <= '0;
      line_q    <= '0;
      dv_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
      bmode_q   <= BORDER_ZERO;
      s1_q      <= '0;
      sync2_q   <= '0;
      win_q     <= '0;
      ovf_q     <= 1'b0;
      colsr_q   <= '{default: '0};
    end else begin
      col_q     <= col_d;
      line_q    <= line_d;
      dv_prev_q <= dv_prev_d;
      vs_prev_q <= vs_prev_d;
      bmode_q   <= bmode_d;
      s1_q      <= s1_d;
      sync2_q   <= sync2_d;
      win_q     <= win_d;
      ovf_q     <= ovf_d;
      colsr_q   <= colsr_d;
    end
  end

  assign win    = win_q;
  assign out_dv = sync2_q.dv;
  assign out_hs = sync2_q.hs;
  assign out_vs = sync2_q.vs;
  assign ovf    = ovf_q;
endmodule

// File: doc/hdmi_window_gen.md
HDMI_WINDOW_GEN -- requirements
Module: hdmi_window_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 8, bits per colour component.
REQ-002 SHALL have parameter CHANNELS, 3, colour channels per pixel.
REQ-003 SHALL have parameter KERNEL, 5, window edge length; odd, 3..7.
REQ-004 SHALL have parameter MAX_LINE, 2048, maximum active pixels per line.
REQ-005 SHALL have port clk  input  1  single clock for all logic (one clock; reset is asynchronous and active-low).
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port in_data  input  CHANNELS*DATA_WIDTH  pixel; channel ch at [ch*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have ports in_dv / in_hs / in_vs  input  1 each  data valid, hsync, vsync.
REQ-009 SHALL have port border_mode  input  1  0 = zero fill, 1 = replicate nearest valid pixel.
REQ-010 SHALL have port win  output  CHANNELS*KERNEL*KERNEL*DATA_WIDTH  window; element (r,c), channel ch at [((ch*KERNEL*KERNEL)+r*KERNEL+c)*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have ports out_dv / out_hs / out_vs  output  1 each  sync signals aligned to win.
REQ-012 SHALL have port ovf  output  1  sticky line-overflow flag.

Function
REQ-013 Window SHALL be trailing: element (KERNEL-1,KERNEL-1) is the current pixel (x,y); element (r,c) is pixel (x-(KERNEL-1-c), y-(KERNEL-1-r)).
REQ-014 Latency SHALL be exactly 2 cycles: win, out_dv, out_hs, out_vs reflect the input presented 2 cycles earlier.
REQ-015 When out_dv = 0, win SHALL hold its last value.
REQ-016 Column counter SHALL increment per in_dv = 1 cycle and clear on the in_dv falling edge (line end).
REQ-017 Line counter SHALL increment at each line end, saturating at KERNEL-1; clear on in_vs rising edge.
REQ-018 in_vs rising edge coincident with in_dv = 1 SHALL take priority: that pixel is (0,0) of the new frame.
REQ-019 KERNEL-1 line memories SHALL store the previous KERNEL-1 lines, written at the column address, read one cycle ahead.
REQ-020 Out-of-frame elements (column < 0 or row < 0) SHALL be 0 when border_mode = 0, and the nearest in-frame element of the same window when border_mode = 1 (row clamp, then column clamp).
REQ-021 border_mode SHALL be sampled on in_vs rising edge and held constant for the frame.
REQ-022 Pixels with column >= MAX_LINE SHALL NOT be written to memory; ovf SHALL set and remain 1 until the next in_vs rising edge.
REQ-023 in_hs SHALL only be delayed; line boundaries SHALL derive from in_dv alone.

Reset
REQ-024 While rst_n = 0: win = 0, out_dv = out_hs = out_vs = 0, ovf = 0, counters = 0, sampled border_mode = 0.
REQ-025 Line memories SHALL NOT be reset; border masking SHALL hide stale contents.
REQ-026 After mid-frame reset release, the next line SHALL be treated as row 0 (rows above border-filled) until in_vs realigns.

Structure
REQ-027 Package hdmi_pkg SHALL hold default DATA_WIDTH/CHANNELS/KERNEL/MAX_LINE and constants BORDER_ZERO = 0, BORDER_REPL = 1.
REQ-028 One sub-module hdmi_line_ram (simple dual-port, synchronous read, width CHANNELS*DATA_WIDTH, depth MAX_LINE) SHALL be instantiated KERNEL-1 times.
REQ-029 win SHALL feed calculate_median instances per channel unchanged.

Verification
REQ-030 KERNEL=3, CHANNELS=1, 4x4 frame of value 10*y+x, border_mode=0 -> window at (2,2) = {0,1,2,10,11,12,20,21,22}, at (0,0) = eight 0s then 0.
REQ-031 Same frame, border_mode=1 -> window at (0,0) = nine 0s; at (1,0) = {0,0,1,0,0,1,0,0,1}.
REQ-032 Toggle border_mode mid-frame -> no change until next in_vs rising edge.
REQ-033 MAX_LINE=4, 6-pixel line -> ovf = 1 from pixel 4 until next in_vs rise; out_dv/hs/vs still delayed by 2.
REQ-034 rst_n pulsed low at row 2 -> outputs 0 during reset; first line afterwards border-filled as row 0.
REQ-035 in_vs rise coincident with in_dv -> pixel treated as (0,0); latency 2 cycles on all sync outputs.
